lsu_access_sequencer: RTL and testbench
=======================================

Name: lsu_access_sequencer

Overview:
- Load/store sequencer directly upstream of the data memory; drives its address, write data, size, extension and write-enable inputs.
- Takes one memory request per transaction from the execute stage, decodes funct3, and issues aligned accesses in a single access cycle.
- Splits misaligned halfword/word accesses into sequential byte accesses and reassembles load data.
- Returns a registered response and a busy/stall flag to the core.

Parameters:
SIZE, 32, address/data width
MISALIGN_EN, 1, 1 = split misaligned accesses; 0 = reject misaligned accesses with resp_err and no memory access

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when req_valid&req_ready
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  SIZE  byte address
req_wdata  in  SIZE  store data (LSB-aligned)
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  SIZE  extended load data (0 for stores/errors)
resp_err  out  1  illegal funct3, or misaligned with MISALIGN_EN=0
resp_split  out  1  response came from a split access
busy  out  1  stall to core: state != IDLE
mem_addr  out  SIZE  data-memory address
mem_wdata  out  SIZE  data-memory write data
mem_size  out  2  00 byte, 01 half, 10 word
mem_ext  out  1  0 sign-extend, 1 zero-extend
mem_we  out  1  data-memory write enable
mem_rdata  in  SIZE  data-memory read data (combinational)

Behaviour:
- Reset (rst=0, async): state=IDLE, byte count=0, assembly reg=0, resp_valid=0, resp_rdata=0, resp_err=0, resp_split=0.
- req_ready=1 only in IDLE. Requests arriving while busy are not accepted; the requester holds them stable.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other funct3/we combination is illegal: no memory access (mem_we=0), go to RESP with resp_err=1.
- Alignment: half is misaligned if addr[0]=1. Word is misaligned if addr[1:0]!=0. Bytes are always aligned.

States:
- IDLE:
  - Aligned legal request: issue combinationally in the acceptance cycle. mem_addr=req_addr, mem_size from funct3[1:0], mem_ext=funct3[2], mem_we=req_we, mem_wdata=req_wdata.
  - Load data is captured into resp_rdata at that clock edge. Next state RESP.
  - Misaligned and MISALIGN_EN=1: capture addr, wdata, funct3, we; set N=2 (half) or 4 (word); count=0. Next state SPLIT, no access this cycle.
  - Misaligned and MISALIGN_EN=0: error path, next state RESP.
- SPLIT: each cycle issues byte k=count.
  - mem_addr=base+k, mod 2^32 wrap.
  - mem_size=00, mem_ext=1, mem_we=we, mem_wdata[7:0]=wdata[8k+7:8k], upper bits 0.
  - Loads write mem_rdata[7:0] into assembly byte k (little-endian).
  - After k=N-1, next state RESP. For loads, resp_rdata is sign- or zero-extended from bit 15/31 per funct3[2].
- RESP: resp_valid=1 for exactly one cycle with rdata/err/split. Next state IDLE.
- mem_we=0 in every cycle that is not an issue cycle; other mem outputs are don't-care then.
- Latency, acceptance to resp_valid:
  - Aligned or error: 1 cycle.
  - Split half: 3 cycles.
  - Split word: 5 cycles.
  - Throughput: one transaction per 2 cycles minimum.
- Reset mid-SPLIT: abort immediately; no response. Bytes of a split store already written stay written (no rollback).
- Stores return resp_rdata=0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - mem_size encodings: SZ_B, SZ_H, SZ_W.
  - State encoding: IDLE, SPLIT, RESP.
- One sub-module: lsu_load_format (combinational). Inputs are raw assembled data, size and extension type; output is the 32-bit extended value.

Test Plan:
- Memory word 0x8899AABB at 0x10 (little-endian); LW at 0x10 -> resp_valid 1 cycle after accept, rdata=0x8899AABB, split=0.
- LB at 0x13 -> 0xFFFFFF88; LBU at 0x13 -> 0x00000088; LHU at 0x12 -> 0x00008899.
- LH at 0x11 (misaligned) -> two byte reads at 0x11, 0x12; resp 3 cycles after accept with rdata=0xFFFF99AA, split=1, busy high for 3 cycles.
- SW 0x11223344 at 0x12 -> four mem_we cycles, size 00: 0x12=44, 0x13=33, 0x14=22, 0x15=11. Readback LW 0x10=0x3344xxxx, LW 0x14=0xxxxx1122.
- funct3=011 load, and store with funct3=100 -> resp_err=1 after 1 cycle, mem_we never asserted. MISALIGN_EN=0 with LW at 0x01 -> resp_err=1, no access.
- Assert rst low during byte 2 of a split SW at 0x21 -> outputs reset at once, no resp_valid, bytes 0x21/0x22 written, 0x23/0x24 untouched. Next request accepted normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants for the load/store access sequencer
// Holds RV32I load/store funct3 codes, data-memory size encodings, FSM state
// encodings and the funct3 legality check used by the sequencer.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SPLIT = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    // Stores only have signed encodings; loads add the unsigned byte/half forms.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_load_format.sv
// rtl/lsu_load_format.sv - sign/zero extension of raw load data
// Ports: i_data raw little-endian data (byte 0 in [7:0]), i_size access size,
//        i_zext 1 = zero-extend / 0 = sign-extend, o_data extended result.
module lsu_load_format
    import lsu_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] i_data,
    input  logic [1:0]      i_size,
    input  logic            i_zext,
    output logic [SIZE-1:0] o_data
);

    always_comb begin
        case (i_size)
            SZ_B:    o_data = {{(SIZE-8){~i_zext & i_data[7]}}, i_data[7:0]};
            SZ_H:    o_data = {{(SIZE-16){~i_zext & i_data[15]}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/lsu_access_sequencer.sv
// rtl/lsu_access_sequencer.sv - load/store sequencer in front of the data memory
// Ports: i_clk/i_rst (async active-low) clock and reset;
//        i_req_* / o_req_ready  request handshake from execute (we, funct3, addr, wdata);
//        o_resp_*               one-cycle registered response (rdata, err, split);
//        o_busy                 stall to core while not idle;
//        o_mem_* / i_mem_rdata  data-memory access port (combinational read data).
module lsu_access_sequencer
    import lsu_pkg::*;
#(
    parameter int SIZE        = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [2:0]      i_req_funct3,
    input  logic [SIZE-1:0] i_req_addr,
    input  logic [SIZE-1:0] i_req_wdata,
    output logic            o_resp_valid,
    output logic [SIZE-1:0] o_resp_rdata,
    output logic            o_resp_err,
    output logic            o_resp_split,
    output logic            o_busy,
    output logic [SIZE-1:0] o_mem_addr,
    output logic [SIZE-1:0] o_mem_wdata,
    output logic [1:0]      o_mem_size,
    output logic            o_mem_ext,
    output logic            o_mem_we,
    input  logic [SIZE-1:0] i_mem_rdata
);

    logic [1:0]      r_state;
    logic [2:0]      r_cnt;
    logic [2:0]      r_last;
    logic [SIZE-1:0] r_addr;
    logic [SIZE-1:0] r_wdata;
    logic [2:0]      r_f3;
    logic            r_we;
    logic [SIZE-1:0] r_asm;
    logic [SIZE-1:0] r_resp_rdata;
    logic            r_resp_err;
    logic            r_resp_split;

    logic            w_idle;
    logic            w_split;
    logic            w_accept;
    logic            w_legal;
    logic            w_misal;
    logic            w_go_aligned;
    logic            w_go_split;
    logic            w_last;
    logic [5:0]      w_bit_idx;
    logic [7:0]      w_wbyte;
    logic [SIZE-1:0] w_asm_next;
    logic [SIZE-1:0] w_fmt_in;
    logic [1:0]      w_fmt_size;
    logic            w_fmt_zext;
    logic [SIZE-1:0] w_fmt_out;

    assign w_idle       = (r_state == IDLE);
    assign w_split      = (r_state == SPLIT);
    assign w_accept     = i_req_valid & w_idle;
    assign w_legal      = f3_legal(i_req_we, i_req_funct3);
    assign w_misal      = ((i_req_funct3[1:0] == SZ_H) & i_req_addr[0]) |
                          ((i_req_funct3[1:0] == SZ_W) & (|i_req_addr[1:0]));
    assign w_go_aligned = w_accept & w_legal & ~w_misal;
    assign w_go_split   = w_accept & w_legal & w_misal & MISALIGN_EN;
    assign w_last       = w_split & (r_cnt == r_last);

    // Byte k of the split transfer lives at bit 8k of the captured data/assembly.
    assign w_bit_idx = {r_cnt, 3'b000};
    assign w_wbyte   = r_wdata[w_bit_idx +: 8];

    always_comb begin
        w_asm_next                  = r_asm;
        w_asm_next[w_bit_idx +: 8]  = i_mem_rdata[7:0];
    end

    // One formatter serves both paths: raw memory data on an aligned issue,
    // the assembly including the byte arriving now on the last split beat.
    assign w_fmt_in   = w_split ? w_asm_next : i_mem_rdata;
    assign w_fmt_size = w_split ? r_f3[1:0]  : i_req_funct3[1:0];
    assign w_fmt_zext = w_split ? r_f3[2]    : i_req_funct3[2];

    lsu_load_format #(.SIZE(SIZE)) u_load_format (
        .i_data (w_fmt_in),
        .i_size (w_fmt_size),
        .i_zext (w_fmt_zext),
        .o_data (w_fmt_out)
    );

    always_comb begin
        if (w_split) begin
            o_mem_addr  = r_addr + {{(SIZE-3){1'b0}}, r_cnt};
            o_mem_wdata = {{(SIZE-8){1'b0}}, w_wbyte};
            o_mem_size  = SZ_B;
            o_mem_ext   = 1'b1;
            o_mem_we    = r_we;
        end else begin
            o_mem_addr  = i_req_addr;
            o_mem_wdata = i_req_wdata;
            o_mem_size  = i_req_funct3[1:0];
            o_mem_ext   = i_req_funct3[2];
            o_mem_we    = w_go_aligned & i_req_we;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_last       <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_f3         <= 3'd0;
            r_we         <= 1'b0;
            r_asm        <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_resp_split <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_resp_split <= 1'b0;
                        if (w_go_split) begin
                            r_state <= SPLIT;
                            r_addr  <= i_req_addr;
                            r_wdata <= i_req_wdata;
                            r_f3    <= i_req_funct3;
                            r_we    <= i_req_we;
                            r_cnt   <= 3'd0;
                            r_last  <= (i_req_funct3[1:0] == SZ_W) ? 3'd3 : 3'd1;
                            r_asm   <= '0;
                        end else begin
                            // Aligned issue completes now; anything else is an error.
                            r_state      <= RESP;
                            r_resp_err   <= ~w_go_aligned;
                            r_resp_rdata <= (w_go_aligned & ~i_req_we) ? w_fmt_out : '0;
                        end
                    end
                end
                SPLIT: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (!r_we) begin
                        r_asm <= w_asm_next;
                    end
                    if (w_last) begin
                        r_state      <= RESP;
                        r_resp_err   <= 1'b0;
                        r_resp_split <= 1'b1;
                        r_resp_rdata <= r_we ? '0 : w_fmt_out;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready  = w_idle;
    assign o_busy       = ~w_idle;
    assign o_resp_valid = (r_state == RESP);
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;
    assign o_resp_split = r_resp_split;

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// tb/tb_lsu_access_sequencer.sv - self-checking bench for lsu_access_sequencer
module tb_lsu_access_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, resp_split, busy;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
    logic        mem_ext, mem_we;

    logic        d0_req_valid, d0_req_ready, d0_req_we;
    logic [2:0]  d0_req_funct3;
    logic [31:0] d0_req_addr, d0_req_wdata;
    logic        d0_resp_valid, d0_resp_err, d0_resp_split, d0_busy;
    logic [31:0] d0_resp_rdata;
    logic [31:0] d0_mem_addr, d0_mem_wdata, d0_mem_rdata;
    logic [1:0]  d0_mem_size;
    logic        d0_mem_ext, d0_mem_we;

    int nvec = 0;
    int nerr = 0;
    int we_count = 0;
    int d0_we_count = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       mem_load;
    logic [7:0] ra;

    always #5 clk = ~clk;

    lsu_access_sequencer #(.SIZE(32), .MISALIGN_EN(1'b1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_resp_split(resp_split), .o_busy(busy),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_size(mem_size),
        .o_mem_ext(mem_ext), .o_mem_we(mem_we), .i_mem_rdata(mem_rdata)
    );

    lsu_access_sequencer #(.SIZE(32), .MISALIGN_EN(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(d0_req_valid), .o_req_ready(d0_req_ready), .i_req_we(d0_req_we),
        .i_req_funct3(d0_req_funct3), .i_req_addr(d0_req_addr), .i_req_wdata(d0_req_wdata),
        .o_resp_valid(d0_resp_valid), .o_resp_rdata(d0_resp_rdata), .o_resp_err(d0_resp_err),
        .o_resp_split(d0_resp_split), .o_busy(d0_busy),
        .o_mem_addr(d0_mem_addr), .o_mem_wdata(d0_mem_wdata), .o_mem_size(d0_mem_size),
        .o_mem_ext(d0_mem_ext), .o_mem_we(d0_mem_we), .i_mem_rdata(d0_mem_rdata)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 29 + 7) & 255);
    endfunction

    // Byte-addressed data memory, 256 bytes, wraps on the low address byte.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        end else if (mem_we) begin
            we_count <= we_count + 1;
            mem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_size != 2'b00) mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            if (mem_size == 2'b10) begin
                mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    always @(posedge clk) begin
        if (d0_mem_we) d0_we_count <= d0_we_count + 1;
    end

    assign ra        = mem_addr[7:0];
    assign mem_rdata = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_legal(input logic we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int n = nbytes(f3);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v = v + (64'(ref_mem[8'(addr + 32'(i))]) << (8 * i));
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                        output logic err, output logic split, output int writes, output int bad);
        int w0;
        bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        w0 = we_count;
        if (!req_ready) bad++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            if (!busy || req_ready) bad++;
            @(negedge clk);
            lat++;
        end
        if (!busy) bad++;
        rd = resp_rdata; err = resp_err; split = resp_split;
        writes = we_count - w0;
        @(negedge clk);
        if (resp_valid || busy) bad++;
    endtask

    task automatic run_chk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd);
        int n, lat, writes, bad;
        logic err, split;
        bit legal, mis;
        logic [31:0] exp_rd;
        string p;
        n      = nbytes(f3);
        legal  = is_legal(we, f3);
        mis    = (addr % 32'(n)) != 0;
        exp_rd = (legal && !we) ? ref_load(f3, addr) : 32'd0;
        p      = $sformatf("we=%0d f3=%0d a=%08h", we, f3, addr);
        xact(we, f3, addr, wdata, lat, rd, err, split, writes, bad);
        chk({p, " latency"}, 32'(lat), (legal && mis) ? 32'(1 + n) : 32'd1);
        chk({p, " rdata"}, rd, exp_rd);
        chk({p, " err"}, {31'd0, err}, {31'd0, !legal});
        chk({p, " split"}, {31'd0, split}, {31'd0, legal && mis});
        chk({p, " mem_we_cycles"}, 32'(writes), (legal && we) ? (mis ? 32'(n) : 32'd1) : 32'd0);
        chk({p, " busy_ready_pulse"}, 32'(bad), 32'd0);
        if (legal && we) for (int i = 0; i < n; i++) ref_mem[8'(addr + 32'(i))] = wdata[8 * i +: 8];
    endtask

    task automatic d0_run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic exp_err, input logic [31:0] exp_rd, input int exp_wr);
        int w0;
        string p;
        p = $sformatf("noalign we=%0d f3=%0d a=%08h", we, f3, addr);
        @(negedge clk);
        d0_req_valid = 1'b1; d0_req_we = we; d0_req_funct3 = f3; d0_req_addr = addr;
        d0_req_wdata = 32'h5A5A5A5A;
        w0 = d0_we_count;
        chk({p, " ready"}, {31'd0, d0_req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        d0_req_valid = 1'b0;
        chk({p, " resp_valid"}, {31'd0, d0_resp_valid}, 32'd1);
        chk({p, " err"}, {31'd0, d0_resp_err}, {31'd0, exp_err});
        chk({p, " rdata"}, d0_resp_rdata, exp_rd);
        chk({p, " split"}, {31'd0, d0_resp_split}, 32'd0);
        chk({p, " mem_we_cycles"}, 32'(d0_we_count - w0), 32'(exp_wr));
    endtask

    initial begin
        logic [31:0] rd;
        int diff;
        rst = 1'b0; mem_load = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        d0_req_valid = 1'b0; d0_req_we = 1'b0; d0_req_funct3 = 3'd0; d0_req_addr = 32'd0;
        d0_req_wdata = 32'd0; d0_mem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", {31'd0, resp_err}, 32'd0);
        chk("reset resp_split", {31'd0, resp_split}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        mem_load = 1'b0;
        rst = 1'b1;

        run_chk(1'b1, 3'd2, 32'h10, 32'h8899AABB, rd);
        run_chk(1'b0, 3'd2, 32'h10, 32'h0, rd);
        chk("LW 0x10 value", rd, 32'h8899AABB);
        run_chk(1'b0, 3'd0, 32'h13, 32'h0, rd);
        chk("LB 0x13 value", rd, 32'hFFFFFF88);
        run_chk(1'b0, 3'd4, 32'h13, 32'h0, rd);
        chk("LBU 0x13 value", rd, 32'h00000088);
        run_chk(1'b0, 3'd5, 32'h12, 32'h0, rd);
        chk("LHU 0x12 value", rd, 32'h00008899);
        run_chk(1'b0, 3'd1, 32'h11, 32'h0, rd);
        chk("LH 0x11 split value", rd, 32'hFFFF99AA);
        run_chk(1'b1, 3'd2, 32'h12, 32'h11223344, rd);
        run_chk(1'b0, 3'd2, 32'h10, 32'h0, rd);
        chk("LW 0x10 after split SW", rd, 32'h3344AABB);
        run_chk(1'b0, 3'd2, 32'h14, 32'h0, rd);
        chk("LW 0x14 low half after split SW", {16'd0, rd[15:0]}, 32'h00001122);
        run_chk(1'b0, 3'd3, 32'h10, 32'h0, rd);
        run_chk(1'b1, 3'd4, 32'h10, 32'hDEADBEEF, rd);
        run_chk(1'b1, 3'd5, 32'h11, 32'hDEADBEEF, rd);
        run_chk(1'b0, 3'd7, 32'h12, 32'h0, rd);
        run_chk(1'b0, 3'd1, 32'hFFFFFFFF, 32'h0, rd);
        run_chk(1'b1, 3'd2, 32'hFFFFFFFE, 32'hCAFE1234, rd);

        // Reset in the middle of a split store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h21; req_wdata = 32'hA1B2C3D4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("split byte0 mem_we", {31'd0, mem_we}, 32'd1);
        chk("split byte0 mem_addr", mem_addr, 32'h21);
        chk("split byte0 mem_wdata", mem_wdata, 32'hD4);
        chk("split byte0 mem_size", {30'd0, mem_size}, 32'd0);
        chk("split byte0 mem_ext", {31'd0, mem_ext}, 32'd1);
        @(negedge clk);
        chk("split byte1 mem_addr", mem_addr, 32'h22);
        @(negedge clk);
        chk("split byte2 mem_addr", mem_addr, 32'h23);
        rst = 1'b0;
        #1;
        chk("abort mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort resp_rdata", resp_rdata, 32'd0);
        chk("abort resp_err", {31'd0, resp_err}, 32'd0);
        chk("abort resp_split", {31'd0, resp_split}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no resp_valid", {31'd0, resp_valid}, 32'd0);
        end
        rst = 1'b1;
        ref_mem[8'h21] = 8'hD4;
        ref_mem[8'h22] = 8'hC3;
        chk("abort mem 0x21", {24'd0, mem[8'h21]}, 32'hD4);
        chk("abort mem 0x22", {24'd0, mem[8'h22]}, 32'hC3);
        chk("abort mem 0x23 untouched", {24'd0, mem[8'h23]}, {24'd0, init_byte(8'h23)});
        chk("abort mem 0x24 untouched", {24'd0, mem[8'h24]}, {24'd0, init_byte(8'h24)});
        run_chk(1'b0, 3'd2, 32'h20, 32'h0, rd);

        d0_run(1'b0, 3'd2, 32'h01, 1'b1, 32'd0, 0);
        d0_run(1'b0, 3'd2, 32'h04, 1'b0, 32'hCAFEF00D, 0);
        d0_run(1'b1, 3'd1, 32'h03, 1'b1, 32'd0, 0);
        d0_run(1'b1, 3'd1, 32'h02, 1'b0, 32'd0, 1);

        for (int t = 0; t < 80; t++) begin
            run_chk(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
                    $urandom, rd);
        end

        diff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
        chk("final memory image bytes differing", 32'(diff), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
